// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half adders and an OR of their carries.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .x(x),
    .y(y),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .x(s0),
    .y(cin),
    .s(s),
    .c(c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: s = x ^ y, c = x & y.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit unsigned add, one bit per clock LSB first, through a
// single full-adder cell with its carry fed back through a flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sra_q, srb_q, sr_sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_q, cout_q;
  logic             bit_s, bit_co, last;

  fa_cell u_fa (
    .x  (sra_q[0]),
    .y  (srb_q[0]),
    .cin(c_q),
    .s  (bit_s),
    .co (bit_co)
  );

  assign last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StShift;
      end
      StShift: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = start ? StShift : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sra_q    <= '0;
      srb_q    <= '0;
      sr_sum_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle, StDone: begin
          // cout deliberately holds until the new result is complete
          if (start) begin
            sra_q    <= a;
            srb_q    <= b;
            sr_sum_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
          end
        end
        StShift: begin
          sra_q    <= {1'b0, sra_q[WIDTH-1:1]};
          srb_q    <= {1'b0, srb_q[WIDTH-1:1]};
          sr_sum_q <= {bit_s, sr_sum_q[WIDTH-1:1]};
          c_q      <= bit_co;
          cnt_q    <= cnt_q + CntW'(1);
          if (last) cout_q <= bit_co;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sr_sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 2 and 32.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0, start2 = 1'b0, start32 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic [1:0]  a2 = '0, b2 = '0, sum2;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        cout8, busy8, done8, cout2, busy2, done2, cout32, busy32, done32;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .sum(sum32), .cout(cout32), .busy(busy32), .done(done32)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
    case (w)
      2: begin start2 = s; a2 = av[1:0]; b2 = bv[1:0]; end
      8: begin start8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
      default: begin start32 = s; a32 = av; b32 = bv; end
    endcase
  endtask

  function automatic logic [31:0] rd_sum(input int w);
    case (w)
      2:       return {30'd0, sum2};
      8:       return {24'd0, sum8};
      default: return sum32;
    endcase
  endfunction

  function automatic logic rd_cout(input int w);
    case (w)
      2:       return cout2;
      8:       return cout8;
      default: return cout32;
    endcase
  endfunction

  function automatic logic rd_busy(input int w);
    case (w)
      2:       return busy2;
      8:       return busy8;
      default: return busy32;
    endcase
  endfunction

  function automatic logic rd_done(input int w);
    case (w)
      2:       return done2;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  // One addition from idle: start pulsed for a single edge, checks latency, busy length,
  // result, single-cycle done and result holding. Called at a negedge.
  task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] esum, input logic ecout, input string tag);
    int lat = 0;
    int busy_n = 0;
    logic got = 1'b0;
    drive(w, 1'b1, av, bv);
    for (int k = 0; k < 3 * w + 10 && !got; k++) begin
      @(negedge clk);
      if (k == 0) drive(w, 1'b0, av, bv);
      lat++;
      if (rd_done(w)) got = 1'b1;
      else if (rd_busy(w)) busy_n++;
    end
    check({tag, " done seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(w + 1));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(w));
    check({tag, " sum"}, 64'(rd_sum(w)), 64'(esum));
    check({tag, " cout"}, 64'(rd_cout(w)), 64'(ecout));
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(rd_done(w)), 64'd0);
    check({tag, " sum held"}, 64'(rd_sum(w)), 64'(esum));
  endtask

  // Reference: plain integer addition, split into low WIDTH bits and carry bit.
  task automatic rand_ops(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] av, bv;
      longint unsigned full, mask;
      mask = (64'd1 << w) - 64'd1;
      av = 32'($urandom() & mask);
      bv = 32'($urandom() & mask);
      full = longint'(av) + longint'(bv);
      do_op(w, av, bv, 32'(full & mask), full[w], $sformatf("rand w%0d #%0d", w, i));
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   dn;
    int   busy_lo;

    vecs[0] = '{a: 8'h5A, b: 8'h33, sum: 8'h8D, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h20, sum: 8'h30, cout: 1'b0};
    vecs[4] = '{a: 8'h01, b: 8'h01, sum: 8'h02, cout: 1'b0};
    vecs[5] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
    vecs[7] = '{a: 8'hA5, b: 8'h5B, sum: 8'h00, cout: 1'b1};

    repeat (2) @(negedge clk);
    check("reset sum8", 64'(sum8), 64'd0);
    check("reset cout8", 64'(cout8), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset sum32", 64'(sum32), 64'd0);
    // start during reset must be ignored
    start8 = 1'b1;
    @(negedge clk);
    check("reset beats start", 64'(busy8), 64'd0);
    start8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 64'(busy8), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(8, 32'(vecs[i].a), 32'(vecs[i].b), 32'(vecs[i].sum), vecs[i].cout,
            $sformatf("vec %0d", i));
    end

    // start pulsed mid-shift is ignored
    dn = 0;
    drive(8, 1'b1, 32'h10, 32'h20);
    @(negedge clk);
    drive(8, 1'b0, 32'h10, 32'h20);
    @(negedge clk);
    @(negedge clk);
    drive(8, 1'b1, 32'hFF, 32'hFF);
    @(negedge clk);
    drive(8, 1'b0, 32'hFF, 32'hFF);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) begin
        dn++;
        check("ignore sum", 64'(sum8), 64'h30);
        check("ignore cout", 64'(cout8), 64'd0);
      end
    end
    check("ignore done count", 64'(dn), 64'd1);
    check("ignore idle after", 64'(busy8), 64'd0);

    // back-to-back with start held high
    dn = 0;
    busy_lo = 0;
    drive(8, 1'b1, 32'h01, 32'h02);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) drive(8, 1'b1, 32'h80, 32'h80);
      if (!busy8) busy_lo++;
      if (done8) dn++;
      if (k == 9) begin
        check("b2b first done", 64'(done8), 64'd1);
        check("b2b first sum", 64'(sum8), 64'h03);
        check("b2b first cout", 64'(cout8), 64'd0);
      end
      if (k == 10) begin
        check("b2b sum cleared", 64'(sum8), 64'h00);
        check("b2b cout held", 64'(cout8), 64'd0);
      end
      if (k == 18) begin
        check("b2b second done", 64'(done8), 64'd1);
        check("b2b second sum", 64'(sum8), 64'h00);
        check("b2b second cout", 64'(cout8), 64'd1);
      end
    end
    drive(8, 1'b0, 32'h80, 32'h80);
    check("b2b done count", 64'(dn), 64'd2);
    check("b2b busy low cycles", 64'(busy_lo), 64'd2);
    @(negedge clk);
    @(negedge clk);

    // async reset mid-operation (cout is 1 from the previous result)
    drive(8, 1'b1, 32'hAA, 32'h55);
    @(posedge clk);
    #1 drive(8, 1'b0, 32'hAA, 32'h55);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst sum", 64'(sum8), 64'd0);
    check("midrst cout", 64'(cout8), 64'd0);
    check("midrst busy", 64'(busy8), 64'd0);
    check("midrst done", 64'(done8), 64'd0);
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("midrst no done", 64'(dn), 64'd0);
    do_op(8, 32'h01, 32'h01, 32'h02, 1'b0, "after rst");

    rand_ops(8, 10);
    rand_ops(2, 12);
    rand_ops(32, 6);
    do_op(2, 32'h3, 32'h3, 32'h2, 1'b1, "w2 max");
    do_op(32, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, "w32 ripple");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
